// File: rtl/karatsuba_seq.sv
// Sequential one-level Karatsuba multiplier: three half-width sub-products share one
// (N/2+1)-bit multiplier over successive cycles, then combine into a 2N-bit product.
module karatsuba_seq #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           SGN,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Z
);
    localparam int H  = N / 2;
    localparam int W  = 2 * N;
    localparam int PW = N + 2;

    if (N < 4 || (N % 2) != 0) begin : g_bad_n
        $error("karatsuba_seq: N must be even and >= 4");
    end

    typedef enum logic [2:0] {IDLE, MUL0, MUL2, MUL1, COMB} state_t;
    state_t state;

    logic [N-1:0]  a, b;
    logic          neg;
    logic [PW-1:0] p0, p1, p2;
    logic [H-1:0]  al, ah, bl, bh;
    logic [H:0]    mul_a, mul_b;
    logic [PW-1:0] mul_p;
    logic [N-1:0]  x_mag, y_mag;
    logic [PW-1:0] m;
    logic [W-1:0]  r;

    assign {ah, al} = a;
    assign {bh, bl} = b;
    assign busy     = (state != IDLE);

    // Negation modulo 2^N maps -2^(N-1) onto itself, which is the correct unsigned magnitude.
    assign x_mag = (SGN && X[N-1]) ? -X : X;
    assign y_mag = (SGN && Y[N-1]) ? -Y : Y;

    // Operand steering for the single shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MUL0: begin
                mul_a = {1'b0, al};
                mul_b = {1'b0, bl};
            end
            MUL2: begin
                mul_a = {1'b0, ah};
                mul_b = {1'b0, bh};
            end
            MUL1: begin
                mul_a = (H+1)'(al) + (H+1)'(ah);
                mul_b = (H+1)'(bl) + (H+1)'(bh);
            end
            default: ;
        endcase
    end

    assign mul_p = PW'(mul_a) * PW'(mul_b);
    assign m     = p1 - p2 - p0;
    assign r     = (W'(p2) << N) + (W'(m) << H) + W'(p0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            Z     <= '0;
            a     <= '0;
            b     <= '0;
            neg   <= 1'b0;
            p0    <= '0;
            p1    <= '0;
            p2    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a     <= x_mag;
                    b     <= y_mag;
                    neg   <= SGN & (X[N-1] ^ Y[N-1]);
                    state <= MUL0;
                end
                MUL0: begin
                    p0    <= mul_p;
                    state <= MUL2;
                end
                MUL2: begin
                    p2    <= mul_p;
                    state <= MUL1;
                end
                MUL1: begin
                    p1    <= mul_p;
                    state <= COMB;
                end
                COMB: begin
                    Z     <= neg ? -r : r;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_seq.sv
// Scoreboard bench: N=16 directed cases plus a random sweep over N=16/4/8/32 instances.
module tb_karatsuba_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start_v = '0;
    logic [3:0]  sgn_v = '0;
    logic [31:0] xv [4];
    logic [31:0] yv [4];
    logic [3:0]  busy_v, done_v;
    logic [31:0] z16;
    logic [7:0]  z4;
    logic [15:0] z8;
    logic [63:0] z32;
    logic [63:0] zz [4];

    logic [63:0] exp_q [4][$];
    int          st_q  [4][$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    karatsuba_seq #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .start(start_v[0]), .SGN(sgn_v[0]),
        .X(xv[0][15:0]), .Y(yv[0][15:0]), .busy(busy_v[0]), .done(done_v[0]), .Z(z16));
    karatsuba_seq #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .start(start_v[1]), .SGN(sgn_v[1]),
        .X(xv[1][3:0]), .Y(yv[1][3:0]), .busy(busy_v[1]), .done(done_v[1]), .Z(z4));
    karatsuba_seq #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .start(start_v[2]), .SGN(sgn_v[2]),
        .X(xv[2][7:0]), .Y(yv[2][7:0]), .busy(busy_v[2]), .done(done_v[2]), .Z(z8));
    karatsuba_seq #(.N(32)) u_dut32 (.clk(clk), .rst(rst), .start(start_v[3]), .SGN(sgn_v[3]),
        .X(xv[3]), .Y(yv[3]), .busy(busy_v[3]), .done(done_v[3]), .Z(z32));

    always_comb begin
        zz[0] = {32'b0, z16};
        zz[1] = {56'b0, z4};
        zz[2] = {48'b0, z8};
        zz[3] = z32;
    end

    function automatic int wid(int i);
        case (i)
            0: return 16;
            1: return 4;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    // Plain integer reference: sign-extend, multiply in 64 bits, truncate to 2n bits.
    function automatic logic [63:0] ref_mul(int n, logic [31:0] x, logic [31:0] y, bit s);
        logic [63:0] mk, mk2, ux, uy;
        longint      sx, sy;
        mk  = (n == 32) ? 64'hFFFF_FFFF : ((64'd1 << n) - 64'd1);
        mk2 = (n == 32) ? '1 : ((64'd1 << (2 * n)) - 64'd1);
        ux  = {32'b0, x} & mk;
        uy  = {32'b0, y} & mk;
        sx  = longint'(ux);
        sy  = longint'(uy);
        if (s && ux[n-1]) sx = sx - (longint'(1) << n);
        if (s && uy[n-1]) sy = sy - (longint'(1) << n);
        return logic'(1) ? (64'(sx * sy) & mk2) : 64'(0);
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic drive(int i, logic [31:0] x, logic [31:0] y, bit s, bit push, logic [63:0] e);
        start_v[i] = 1'b1;
        sgn_v[i]   = s;
        xv[i]      = x;
        yv[i]      = y;
        if (push) begin
            exp_q[i].push_back(e);
            st_q[i].push_back(cyc);
        end
    endtask

    task automatic wait_done(int i);
        for (int k = 0; k < 10; k++) begin
            if (done_v[i]) return;
            @(negedge clk);
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run16(logic [31:0] x, logic [31:0] y, bit s, logic [63:0] e);
        @(negedge clk);
        drive(0, x, y, s, 1'b1, e);
        @(negedge clk);
        start_v = '0;
        wait_done(0);
    endtask

    // Scoreboard: every done pops the oldest expectation and checks value and latency.
    always @(negedge clk) begin
        logic [63:0] e;
        int          s;
        for (int i = 0; i < 4; i++) begin
            if (done_v[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("spurious_done%0d", wid(i)), 64'd1, 64'd0);
                end else begin
                    e = exp_q[i].pop_front();
                    s = st_q[i].pop_front();
                    chk($sformatf("z_n%0d", wid(i)), zz[i], e);
                    chk($sformatf("latency_n%0d", wid(i)), 64'(cyc - s), 64'd5);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            xv[i] = '0;
            yv[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy_v[0]), 64'd0);
        chk("rst_done", 64'(done_v[0]), 64'd0);
        chk("rst_z", zz[0], 64'd0);

        // Unsigned max with exact busy window.
        @(negedge clk);
        drive(0, 32'hFFFF, 32'hFFFF, 1'b0, 1'b1, 64'hFFFE_0001);
        @(negedge clk);
        start_v = '0;
        for (int k = 0; k < 4; k++) begin
            chk("busy_window", 64'(busy_v[0]), 64'd1);
            chk("done_early", 64'(done_v[0]), 64'd0);
            @(negedge clk);
        end
        chk("done_pulse", 64'(done_v[0]), 64'd1);
        chk("busy_in_done", 64'(busy_v[0]), 64'd0);

        run16(32'hFFFF, 32'hFFFF, 1'b1, 64'h0000_0001);
        run16(32'hFFFF, 32'h0005, 1'b1, 64'hFFFF_FFFB);
        run16(32'h8000, 32'h8000, 1'b1, 64'h4000_0000);

        // Back-to-back: restart in the done cycle; Z must hold meanwhile.
        run16(32'h1234, 32'h5678, 1'b0, 64'h0626_0060);
        drive(0, 32'h0, 32'hABCD, 1'b0, 1'b1, 64'h0);
        @(negedge clk);
        start_v = '0;
        for (int k = 0; k < 3; k++) begin
            chk("z_hold", zz[0], 64'h0626_0060);
            @(negedge clk);
        end
        wait_done(0);

        // Start while busy is dropped.
        @(negedge clk);
        drive(0, 32'd3, 32'd4, 1'b0, 1'b1, 64'd12);
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        drive(0, 32'd7, 32'd7, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        start_v = '0;
        wait_done(0);
        repeat (6) begin
            @(negedge clk);
            chk("extra_done", 64'(done_v[0]), 64'd0);
        end

        // Reset while in MUL2 discards the operation.
        @(negedge clk);
        drive(0, 32'hFFFF, 32'hFFFF, 1'b0, 1'b1, 64'd0);
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy_v[0]), 64'd0);
        chk("midrst_done", 64'(done_v[0]), 64'd0);
        chk("midrst_z", zz[0], 64'd0);
        void'(exp_q[0].pop_front());
        void'(st_q[0].pop_front());
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_done", 64'(done_v[0]), 64'd0);
        end

        // Random sweep, all widths in lockstep, alternating modes, back-to-back issue.
        @(negedge clk);
        for (int it = 0; it < 2000; it++) begin
            for (int i = 0; i < 4; i++) begin
                automatic int          n = wid(i);
                automatic bit          s = bit'(it % 2);
                automatic logic [31:0] x = $urandom;
                automatic logic [31:0] y = $urandom;
                if (it % 9 == 0) x = 32'd1 << (n - 1);
                if (it % 13 == 0) y = '1;
                drive(i, x, y, s, 1'b1, ref_mul(n, x, y, s));
            end
            @(negedge clk);
            start_v = '0;
            wait_done(0);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("queue_empty_n%0d", wid(i)), 64'(exp_q[i].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
